instr_encoder: RTL and testbench
================================

# instr_encoder

Encodes decoded instruction fields (kind, registers, funct, immediate) into 32-bit RISC-V instruction words for the R, I, BEQ, JAL, LOAD and STORE classes that `control_unit` decodes. Each accepted request is range-checked, encoded and buffered in a small output FIFO. The block streams program words to instruction-memory loaders and test sequencers over valid/ready handshakes on both sides.

## Interface
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `arst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request; equals !full.
- `in_kind`  in  3  0=R, 1=I (ALU imm), 2=BEQ, 3=JAL, 4=LOAD, 5=STORE, 6/7 illegal.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_funct3`  in  3  funct3; ignored for BEQ (forced 000) and JAL.
- `in_funct7`  in  7  funct7; used by R only.
- `in_imm`  in  32  signed byte immediate/offset.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer takes head word.
- `out_instr`  out  32  FIFO head; 32'h00000013 (NOP) when empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  occupancy.
- `err_illegal`  out  1  one-cycle pulse: illegal kind accepted.
- `err_range`  out  1  one-cycle pulse: immediate out of range/misaligned.
- `instr_count`  out  16  words delivered on output handshake; wraps.

## Operation
- Accept = in_valid & in_ready. Encoding combinational from inputs; on accept, a legal, in-range request is written at the write pointer.
- Encodings (opcode in [6:0]):
  - R: funct7|rs2|rs1|funct3|rd|0110011.
  - I: imm[11:0]|rs1|funct3|rd|0010011. LOAD: same layout, 0000011.
  - STORE: imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011.
  - BEQ: imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11]|1100011.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
- Range rules (in_imm as signed 32-bit): I/LOAD/STORE in [-2048, 2047]; BEQ in [-4096, 4094] and even; JAL in [-1048576, 1048574] and even. R ignores in_imm.
- Violation: request is accepted (handshake completes) but not written; err_range pulses. Illegal kind: accepted, not written, err_illegal pulses; range check not evaluated.
- Output pop = out_valid & out_ready; advances read pointer and increments instr_count (16-bit wrap, FFFF→0000).
- Pointers wrap modulo FIFO_DEPTH; full/empty distinguished by occupancy counter.

## Timing
- Reset (async assert, sync release): pointers=0, fifo_level=0, out_valid=0, in_ready=1, out_instr=32'h00000013, err_* = 0, instr_count=0. Reset mid-stream discards all buffered words.
- Latency: request accepted at edge N appears on out_instr with out_valid=1 after edge N when FIFO was empty (one cycle).
- Error pulses registered: high for exactly the cycle after the accepting edge; back-to-back bad requests give continuous high.
- Full: in_ready=0 even if out_ready=1 the same cycle (no full-pass-through); push re-enabled the cycle after a pop.
- Simultaneous push and pop when neither full nor empty: both occur, fifo_level unchanged.
- Empty with out_ready=1: no pop, instr_count unchanged.
- Dropped (error) request concurrent with pop: only pop takes effect.
- out_instr/out_valid stable while out_valid=1 and out_ready=0.

## Test plan
- R add rd=3,rs1=1,rs2=2,f3=0,f7=0 with out_ready=1 → out_instr=0x002081B3 one cycle later, instr_count=1.
- I rd=5,rs1=0,imm=-1; then STORE rs1=1,rs2=2,f3=010,imm=4 → 0xFFF00293 then 0x0020A223 in order.
- BEQ rs1=1,rs2=2,imm=8 (f3=111 supplied) → 0x00208463; JAL rd=1,imm=16 → 0x010000EF.
- I imm=2048, BEQ imm=7, kind=6 → err_range, err_range, err_illegal single-cycle pulses; fifo_level stays 0, out_instr=0x00000013.
- out_ready=0, push 5 legal words with DEPTH=4 → in_ready=0 after 4th, fifo_level=4; assert out_ready → 4 words out in order, in_ready=1 after first pop, 5th word then accepted.
- Fill 2 words, assert arst mid-cycle → immediately out_valid=0, fifo_level=0, instr_count=0; after release, new push emits correctly from pointer 0.

Source files
------------

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Range-checks and encodes decoded fields into RV32 instruction
//            words, buffered in a small valid/ready output FIFO.
// Revision : 1.0
// ============================================================================
module instr_encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_kind,
  input  logic [4:0]                    in_rd,
  input  logic [4:0]                    in_rs1,
  input  logic [4:0]                    in_rs2,
  input  logic [2:0]                    in_funct3,
  input  logic [6:0]                    in_funct7,
  input  logic [31:0]                   in_imm,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_instr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_illegal,
  output logic                          err_range,
  output logic [15:0]                   instr_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [31:0]      C_NOP  = 32'h0000_0013;
  localparam logic [LVL_W-1:0] C_FULL = LVL_W'(FIFO_DEPTH);

  localparam logic [2:0] C_KIND_R     = 3'd0;
  localparam logic [2:0] C_KIND_I     = 3'd1;
  localparam logic [2:0] C_KIND_BEQ   = 3'd2;
  localparam logic [2:0] C_KIND_JAL   = 3'd3;
  localparam logic [2:0] C_KIND_LOAD  = 3'd4;
  localparam logic [2:0] C_KIND_STORE = 3'd5;

  localparam logic [6:0] C_OPC_R     = 7'b0110011;
  localparam logic [6:0] C_OPC_I     = 7'b0010011;
  localparam logic [6:0] C_OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] C_OPC_STORE = 7'b0100011;
  localparam logic [6:0] C_OPC_BEQ   = 7'b1100011;
  localparam logic [6:0] C_OPC_JAL   = 7'b1101111;

  // ---------------------------------------------------------------------------
  // Immediate range checks and combinational encoding
  // ---------------------------------------------------------------------------
  logic signed [31:0] w_imm_s;
  logic               w_fits_12;
  logic               w_fits_b;
  logic               w_fits_j;

  assign w_imm_s   = $signed(in_imm);
  assign w_fits_12 = (w_imm_s >= -32'sd2048) && (w_imm_s <= 32'sd2047);
  assign w_fits_b  = (w_imm_s >= -32'sd4096) && (w_imm_s <= 32'sd4094) && !in_imm[0];
  assign w_fits_j  = (w_imm_s >= -32'sd1048576) && (w_imm_s <= 32'sd1048574) && !in_imm[0];

  logic [31:0] w_enc_word;
  logic        w_kind_ok;
  logic        w_imm_ok;

  always_comb begin
    w_enc_word = C_NOP;
    w_kind_ok  = 1'b1;
    w_imm_ok   = 1'b1;
    case (in_kind)
      C_KIND_R: begin
        w_enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, C_OPC_R};
      end
      C_KIND_I: begin
        w_enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, C_OPC_I};
        w_imm_ok   = w_fits_12;
      end
      C_KIND_LOAD: begin
        w_enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, C_OPC_LOAD};
        w_imm_ok   = w_fits_12;
      end
      C_KIND_STORE: begin
        w_enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], C_OPC_STORE};
        w_imm_ok   = w_fits_12;
      end
      C_KIND_BEQ: begin
        w_enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                      in_imm[4:1], in_imm[11], C_OPC_BEQ};
        w_imm_ok   = w_fits_b;
      end
      C_KIND_JAL: begin
        w_enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                      in_rd, C_OPC_JAL};
        w_imm_ok   = w_fits_j;
      end
      default: begin
        w_kind_ok = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshakes and FIFO bookkeeping
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [15:0]      count_q, count_d;
  logic             err_ill_q, err_ill_d;
  logic             err_rng_q, err_rng_d;
  logic [31:0]      mem_q [FIFO_DEPTH];

  logic w_push;
  logic w_wr_en;
  logic w_pop;

  // Full blocks input even when a pop is pending the same cycle.
  assign in_ready  = (level_q != C_FULL);
  assign out_valid = (level_q != '0);
  assign w_push    = in_valid && in_ready;
  assign w_wr_en   = w_push && w_kind_ok && w_imm_ok;
  assign w_pop     = out_valid && out_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    count_d   = count_q;
    err_ill_d = w_push && !w_kind_ok;
    err_rng_d = w_push && w_kind_ok && !w_imm_ok;
    if (w_wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_q + 16'd1;
    end
    case ({w_wr_en, w_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      count_q   <= '0;
      err_ill_q <= 1'b0;
      err_rng_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      count_q   <= count_d;
      err_ill_q <= err_ill_d;
      err_rng_q <= err_rng_d;
    end
  end

  // Storage needs no reset: the occupancy counter masks stale entries.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[wr_ptr_q] <= w_enc_word;
    end
  end

  assign out_instr   = out_valid ? mem_q[rd_ptr_q] : C_NOP;
  assign fifo_level  = level_q;
  assign err_illegal = err_ill_q;
  assign err_range   = err_rng_q;
  assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Brief    : Scoreboard bench for instr_encoder with directed and random traffic.
// Revision : 1.0
// ============================================================================
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        arst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [$clog2(DEPTH):0] fifo_level;
  logic        err_illegal, err_range;
  logic [15:0] instr_count;

  instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .arst(arst),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .fifo_level(fifo_level), .err_illegal(err_illegal), .err_range(err_range),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: instruction semantics straight from the field layouts and numeric ranges.
  function automatic void ref_encode(input logic [2:0] k, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [31:0] imm, output bit legal,
                                     output bit in_range, output logic [31:0] w);
    longint v;
    v        = longint'($signed(imm));
    legal    = (k <= 3'd5);
    in_range = 1'b1;
    w        = 32'h0;
    case (k)
      3'd0: w = {f7, rs2, rs1, f3, rd, 7'h33};
      3'd1: begin in_range = (v >= -2048 && v <= 2047); w = {imm[11:0], rs1, f3, rd, 7'h13}; end
      3'd4: begin in_range = (v >= -2048 && v <= 2047); w = {imm[11:0], rs1, f3, rd, 7'h03}; end
      3'd5: begin in_range = (v >= -2048 && v <= 2047);
                  w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23}; end
      3'd2: begin in_range = (v >= -4096 && v <= 4094 && (v % 2 == 0));
                  w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63}; end
      3'd3: begin in_range = (v >= -1048576 && v <= 1048574 && (v % 2 == 0));
                  w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F}; end
      default: w = 32'h0;
    endcase
  endfunction

  // Input-side model: predicts occupancy, handshake flags and error pulses.
  initial begin : model
    int  exp_level = 0;
    bit  exp_ill = 0, exp_rng = 0;
    bit  acc, pop, legal, inr, wr;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (arst) begin
        exp_level = 0; exp_ill = 0; exp_rng = 0; sb.delete();
      end else begin
        check("in_ready", {31'b0, in_ready}, {31'b0, exp_level != DEPTH});
        check("out_valid", {31'b0, out_valid}, {31'b0, exp_level != 0});
        check("fifo_level", 32'(fifo_level), 32'(exp_level));
        check("err_illegal", {31'b0, err_illegal}, {31'b0, exp_ill});
        check("err_range", {31'b0, err_range}, {31'b0, exp_rng});
        acc = in_valid && (exp_level != DEPTH);
        pop = out_ready && (exp_level != 0);
        exp_ill = 0; exp_rng = 0; wr = 0;
        if (acc) begin
          ref_encode(in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, legal, inr, w);
          if (!legal) exp_ill = 1;
          else if (!inr) exp_rng = 1;
          else begin wr = 1; sb.push_back(w); end
        end
        exp_level = exp_level + int'(wr) - int'(pop);
      end
    end
  end

  // Output-side monitor: pops the scoreboard on every output handshake.
  initial begin : monitor
    int          pops = 0;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (arst) begin
        pops = 0;
      end else begin
        check("instr_count", {16'b0, instr_count}, {16'b0, pops[15:0]});
        if (out_valid) begin
          if (out_ready) begin
            if (sb.size() == 0) begin
              check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
              e = sb.pop_front();
              check("out_instr", out_instr, e);
              pops++;
            end
          end
        end else begin
          check("nop_when_empty", out_instr, 32'h0000_0013);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm);
    int waitc = 0;
    in_valid = 1'b1; in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    @(negedge clk);
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 200) check("send_timeout", 32'(waitc), 32'd0);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  int edge_imm [14] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                        -1048577, -1048576, 1048574, 1048575, 1048576};

  initial begin : stim
    arst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'h0000_0013);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_errs", {30'b0, err_illegal, err_range}, 32'd0);
    check("rst_count", {16'b0, instr_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    tick();

    // R add, one-cycle latency and delivery count
    out_ready = 1'b1;
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    check("r_add", out_instr, 32'h0020_81B3);
    tick();
    check("r_count", {16'b0, instr_count}, 32'd1);

    // I then STORE, in order
    out_ready = 1'b0;
    send(3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    send(3'd5, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd4);
    check("i_head", out_instr, 32'hFFF0_0293);
    check("two_level", 32'(fifo_level), 32'd2);
    out_ready = 1'b1;
    tick();
    check("store_word", out_instr, 32'h0020_A223);
    tick();

    // BEQ with funct3 forced to zero, then JAL
    out_ready = 1'b0;
    send(3'd2, 5'd0, 5'd1, 5'd2, 3'b111, 7'd0, 32'd8);
    check("beq", out_instr, 32'h0020_8463);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    send(3'd3, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16);
    check("jal", out_instr, 32'h0100_00EF);
    out_ready = 1'b1;
    repeat (2) tick();

    // Back-to-back bad requests
    send(3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2048);
    check("err_rng_i", {31'b0, err_range}, 32'd1);
    send(3'd2, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7);
    check("err_rng_beq", {31'b0, err_range}, 32'd1);
    send(3'd6, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    check("err_ill", {31'b0, err_illegal}, 32'd1);
    check("err_ill_no_rng", {31'b0, err_range}, 32'd0);
    check("err_level", 32'(fifo_level), 32'd0);
    check("err_nop", out_instr, 32'h0000_0013);
    tick();
    check("err_ill_clear", {31'b0, err_illegal}, 32'd0);

    // Fill to full, then drain while a fifth request waits
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      send(3'd0, 5'(i + 1), 5'd7, 5'd9, 3'(i), 7'h20, 32'd0);
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    check("full_level", 32'(fifo_level), 32'(DEPTH));
    out_ready = 1'b1;
    send(3'd4, 5'd10, 5'd11, 5'd0, 3'b010, 7'd0, 32'hFFFF_F800);
    repeat (8) tick();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(3'd1, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd100);
    send(3'd1, 5'd4, 5'd3, 5'd0, 3'd0, 7'd0, 32'd200);
    #2 arst = 1'b1;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_count", {16'b0, instr_count}, 32'd0);
    repeat (2) tick();
    arst = 1'b0;
    tick();
    out_ready = 1'b1;
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    check("post_rst_word", out_instr, 32'h0020_81B3);
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_kind   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_funct3 = 3'($urandom);
      in_funct7 = 7'($urandom);
      case ($urandom_range(0, 3))
        0: in_imm = 32'($signed($urandom_range(0, 64)) - 32);
        1: in_imm = 32'(edge_imm[$urandom_range(0, 13)]);
        2: in_imm = 32'($signed($urandom_range(0, 4000000)) - 2000000);
        default: in_imm = $urandom;
      endcase
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
